rx_deframer: RTL
================

RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hEB90, the frame sync pattern, MSB received first.
REQ-002 SHALL have parameter MAX_LEN, default 8'd64, the largest accepted payload length in bytes.
REQ-003 SHALL have port clk_32M768, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst_n_32M768, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port bit_en, input, 1 bit: one-cycle strobe marking a recovered-bit slot (1.024 MHz rate).
REQ-006 SHALL have port rx_bit, input, 1 bit: the demodulated serial bit, sampled only when bit_en and rx_valid are both 1.
REQ-007 SHALL have port rx_valid, input, 1 bit: the demodulator lock/valid flag.
REQ-008 SHALL have port data_tdata, output, 8 bits: the payload byte.
REQ-009 SHALL have port data_tvalid, output, 1 bit: the byte is valid.
REQ-010 SHALL have port data_tready, input, 1 bit: the sink accepts the byte.
REQ-011 SHALL have port data_tuser, output, 1 bit: marks the first payload byte of a frame.
REQ-012 SHALL have port data_tlast, output, 1 bit: marks the last payload byte of a frame.
REQ-013 SHALL have port frame_ok, output, 1 bit: one-cycle pulse when the checksum matches.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse on checksum mismatch, bad length, overflow or loss of lock.
REQ-015 SHALL have port inverted, output, 1 bit: the current frame was received phase-inverted (see REQ-031).

Function
REQ-016 Frame format SHALL be: 16-bit SYNC_WORD, 8-bit LEN, LEN payload bytes, 8-bit CHK. All fields are MSB-first. CHK = payload byte sum mod 256.
REQ-017 The FSM SHALL have states HUNT, LEN, PAYLOAD and CHK. Reset state is HUNT.
REQ-018 In HUNT, each sampled bit SHALL shift into a 16-bit register. The FSM SHALL move to LEN on the cycle after the register equals SYNC_WORD.
REQ-019 In LEN, after 8 bits: LEN = 0 or LEN > MAX_LEN SHALL pulse frame_err and return to HUNT. Otherwise the FSM SHALL go to PAYLOAD with the byte counter = LEN.
REQ-020 In PAYLOAD, each completed byte SHALL load the output register one cycle after its 8th bit. On the same cycle data_tvalid SHALL be set, and the byte SHALL be added to the 8-bit running sum (wrap-around).
REQ-021 data_tuser SHALL be 1 with the first payload byte only. data_tlast SHALL be 1 with byte number LEN only. Both SHALL be 0 whenever data_tvalid is 0.
REQ-022 data_tvalid, data_tdata, data_tuser and data_tlast SHALL stay stable until the cycle with data_tvalid and data_tready both 1. data_tvalid SHALL clear on the next cycle unless a new byte completes on that same cycle.
REQ-023 If a new byte completes while the held byte is still unaccepted (overflow), the block SHALL pulse frame_err, drop the frame, clear data_tvalid and return to HUNT.
REQ-024 After the last payload byte the FSM SHALL go to CHK. After 8 bits it SHALL pulse exactly one of frame_ok or frame_err, then return to HUNT with the shift register cleared.
REQ-025 If rx_valid falls in any state other than HUNT, the block SHALL pulse frame_err, clear data_tvalid and return to HUNT.
REQ-026 A held byte SHALL remain presented through the CHK state until it is accepted.
REQ-027 The sync word SHALL NOT be searched for inside a frame: no re-sync before the end of CHK.
REQ-028 The end-of-frame pulse and the HUNT entry SHALL occur on the same cycle. A sync match in HUNT SHALL need 16 fresh bits after that.

Reset
REQ-029 On rst_n_32M768 = 0 at a clock edge, the block SHALL set: state HUNT, shift register 0, counters 0, running sum 0.
REQ-030 On the same reset, all outputs SHALL be 0, including data_tdata = 8'h00. A reset mid-frame SHALL discard the frame with no frame_err pulse.

Configuration
REQ-031 With RX_DEFRAMER_INVERT_EN defined, HUNT SHALL also match ~SYNC_WORD. On that match, inverted SHALL be set and every later bit of the frame SHALL be complemented before use. inverted SHALL clear on return to HUNT.
REQ-032 Without RX_DEFRAMER_INVERT_EN, only SYNC_WORD SHALL match and inverted SHALL be tied to 0.

Structure
REQ-033 The FSM state typedef, SYNC_WORD default and MAX_LEN default SHALL live in shared package psk_frame_pkg.
REQ-034 Sync detection, including the invert variant, SHALL be sub-module rx_sync_correlator: shift register plus compare, outputting a match flag and an inv flag.

Verification
REQ-035 The bench SHALL send sync EB90, LEN 03, bytes 11 22 33, CHK 66, with data_tready held 1. Required: 3 bytes out, tuser on 11, tlast on 33, one frame_ok pulse.
REQ-036 The bench SHALL send the same frame with CHK 67. Required: 3 bytes out, then one frame_err pulse, then state HUNT.
REQ-037 The bench SHALL send LEN 00, and separately LEN 41 with MAX_LEN = 64. Required: frame_err after the LEN byte and no data_tvalid.
REQ-038 The bench SHALL hold data_tready 0 for the whole frame of REQ-035. Required: byte 11 held, frame_err when byte 22 completes, data_tvalid cleared.
REQ-039 With RX_DEFRAMER_INVERT_EN defined, the bench SHALL send the complemented frame of REQ-035. Required: bytes 11 22 33 out, inverted = 1, frame_ok.
REQ-040 The bench SHALL drop rx_valid, and separately assert reset, in the middle of byte 22. Required: frame_err after the rx_valid drop only, all outputs 0 after reset, and the next good frame decoded correctly.

Source files
------------

// File: rtl/psk_frame_pkg.sv
`default_nettype none
// psk_frame_pkg: shared sync/length defaults and deframer state encoding. Rev 1.0
package psk_frame_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
  localparam logic [7:0]  MAX_LEN_DEF   = 8'd64;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;

  function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_deframer_if.sv
`default_nettype none
// rx_deframer_if: payload byte stream with first/last markers. Rev 1.0
interface rx_deframer_if;
  import psk_frame_pkg::*;

  logic [7:0] data_tdata;
  logic       data_tvalid;
  logic       data_tready;
  logic       data_tuser;
  logic       data_tlast;

  modport master (
    output data_tdata, data_tvalid, data_tuser, data_tlast,
    input  data_tready
  );

  modport slave (
    input  data_tdata, data_tvalid, data_tuser, data_tlast,
    output data_tready
  );

endinterface
`default_nettype wire

// File: rtl/rx_sync_correlator.sv
`default_nettype none
// rx_sync_correlator: 16-bit sync shift register and compare; RX_DEFRAMER_INVERT_EN
// adds the complemented-pattern match. Rev 1.0
module rx_sync_correlator
  import psk_frame_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic clk_32M768,
  input  logic rst_n_32M768,
  input  logic shift_en,
  input  logic clear,
  input  logic din,
  output logic match,
  output logic inv
);

  logic [15:0] sr;

  always_ff @(posedge clk_32M768) begin
    if (!rst_n_32M768) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {sr[14:0], din};
    end
  end

  assign match = (sr == SYNC_WORD);

`ifdef RX_DEFRAMER_INVERT_EN
  assign inv = (sr == ~SYNC_WORD);
`else
  assign inv = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/rx_deframer.sv
`default_nettype none
// rx_deframer: serial frame deframer (sync, LEN, payload, additive CHK) to a byte
// stream; RX_DEFRAMER_INVERT_EN accepts phase-inverted frames. Rev 1.0
module rx_deframer
  import psk_frame_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter logic [7:0]  MAX_LEN   = MAX_LEN_DEF
) (
  input  logic                clk_32M768,
  input  logic                rst_n_32M768,
  input  logic                bit_en,
  input  logic                rx_bit,
  input  logic                rx_valid,
  rx_deframer_if.master       data,
  output logic                frame_ok,
  output logic                frame_err,
  output logic                inverted
);

  state_t     state, state_next;
  logic [2:0] bit_cnt;
  logic [6:0] byte_sr;
  logic [7:0] byte_cnt;
  logic [7:0] sum;
  logic       first_byte;
  logic [7:0] out_data;
  logic       out_valid, out_user, out_last;
  logic       inv_flag;
  logic       sync_match, sync_inv;
  logic       sample, bit_v, byte_done, overflow;
  logic       drop, ok_next, err_next;
  logic [7:0] new_byte;

  assign sample    = bit_en & rx_valid;
  assign bit_v     = rx_bit ^ inv_flag;
  assign new_byte  = {byte_sr, bit_v};
  assign byte_done = sample && (bit_cnt == 3'd7);
  assign overflow  = (state == ST_PAYLOAD) && byte_done && out_valid && !data.data_tready;

  // Register stays cleared for the whole frame, so re-sync needs 16 fresh bits.
  rx_sync_correlator #(.SYNC_WORD(SYNC_WORD)) u_corr (
    .clk_32M768   (clk_32M768),
    .rst_n_32M768 (rst_n_32M768),
    .shift_en     (sample && (state == ST_HUNT)),
    .clear        (state != ST_HUNT),
    .din          (rx_bit),
    .match        (sync_match),
    .inv          (sync_inv)
  );

  always_ff @(posedge clk_32M768) begin
    if (!rst_n_32M768) state <= ST_HUNT;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    ok_next    = 1'b0;
    err_next   = 1'b0;
    drop       = 1'b0;
    if ((state != ST_HUNT) && !rx_valid) begin
      state_next = ST_HUNT;
      err_next   = 1'b1;
      drop       = 1'b1;
    end else begin
      case (state)
        ST_HUNT: if (sync_match || sync_inv) state_next = ST_LEN;
        ST_LEN: begin
          if (byte_done) begin
            if (len_ok(new_byte, MAX_LEN)) begin
              state_next = ST_PAYLOAD;
            end else begin
              state_next = ST_HUNT;
              err_next   = 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (overflow) begin
            state_next = ST_HUNT;
            err_next   = 1'b1;
            drop       = 1'b1;
          end else if (byte_done && (byte_cnt == 8'd1)) begin
            state_next = ST_CHK;
          end
        end
        ST_CHK: begin
          if (byte_done) begin
            state_next = ST_HUNT;
            ok_next    = (new_byte == sum);
            err_next   = (new_byte != sum);
          end
        end
        default: state_next = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_32M768) begin
    if (!rst_n_32M768) begin
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= '0;
      byte_sr    <= '0;
      byte_cnt   <= '0;
      sum        <= '0;
      first_byte <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_user   <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      frame_ok  <= ok_next;
      frame_err <= err_next;
      if ((state == ST_HUNT) || (state_next == ST_HUNT)) begin
        bit_cnt    <= '0;
        byte_sr    <= '0;
        byte_cnt   <= '0;
        sum        <= '0;
        first_byte <= 1'b0;
      end else begin
        if (sample) begin
          bit_cnt <= bit_cnt + 3'd1;
          byte_sr <= new_byte[6:0];
        end
        if ((state == ST_LEN) && byte_done) begin
          byte_cnt   <= new_byte;
          first_byte <= 1'b1;
        end
        if ((state == ST_PAYLOAD) && byte_done) begin
          byte_cnt   <= byte_cnt - 8'd1;
          sum        <= sum + new_byte;
          first_byte <= 1'b0;
        end
      end
      // A held byte survives a normal end of frame; only drops discard it.
      if (drop) begin
        out_valid <= 1'b0;
        out_user  <= 1'b0;
        out_last  <= 1'b0;
      end else if ((state == ST_PAYLOAD) && byte_done) begin
        out_data  <= new_byte;
        out_valid <= 1'b1;
        out_user  <= first_byte;
        out_last  <= (byte_cnt == 8'd1);
      end else if (out_valid && data.data_tready) begin
        out_valid <= 1'b0;
        out_user  <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef RX_DEFRAMER_INVERT_EN
  always_ff @(posedge clk_32M768) begin
    if (!rst_n_32M768)                                   inv_flag <= 1'b0;
    else if (state_next == ST_HUNT)                      inv_flag <= 1'b0;
    else if ((state == ST_HUNT) && sync_inv && !sync_match) inv_flag <= 1'b1;
  end
`else
  assign inv_flag = 1'b0;
`endif

  assign inverted         = inv_flag;
  assign data.data_tdata  = out_data;
  assign data.data_tvalid = out_valid;
  assign data.data_tuser  = out_user;
  assign data.data_tlast  = out_last;

endmodule
`default_nettype wire
